im2col_feeder: RTL and testbench

- Sits between the im2col stage and the systolic array.
- After a start pulse, reads the complete M x N im2col matrix from shared memory through a single synchronous read port and holds it in an internal buffer.
- Then streams it to the array's X input as a diagonally skewed wavefront: lane j is delayed j cycles relative to lane 0.
- Replaces the bench-side bulk copy of the im2col matrix into per-pixel X buffers.

---
 rtl/im2col_feeder.sv | 148 ++++++++++++++
 tb/tb_im2col_feeder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/im2col_feeder.sv
// rtl/im2col_feeder.sv - loads the M x N im2col matrix from memory and streams it as a skewed wavefront
module im2col_feeder #(
  parameter int M = 20,
  parameter int N = 9,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = 32'h00002000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [ADDR_WIDTH-1:0]   addr_rd,
  input  logic [DATA_WIDTH-1:0]   data_rd,
  output logic [DATA_WIDTH*N-1:0] X,
  output logic                    x_valid,
  input  logic                    x_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int DEPTH = M * N;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (M + N > 2) ? $clog2(M + N - 1) : 1;
  localparam logic [IW-1:0] LAST_R = IW'(DEPTH - 1);
  localparam logic [TW-1:0] LAST_T = TW'(M + N - 2);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, STREAM, DONE} state_e;

  state_e                  state_q;
  logic [IW-1:0]           r_q;
  logic [TW-1:0]           t_q;
  logic [TW-1:0]           step_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH*N-1:0] x_q;
  logic [DATA_WIDTH*N-1:0] x_d;
  logic                    x_valid_q;
  logic                    busy_q;
  logic                    done_q;
  // Read-return tracking: p1 marks the cycle the address is on the bus,
  // p2 the cycle the memory drives data_rd for that address.
  logic                    p1_v_q;
  logic [IW-1:0]           p1_idx_q;
  logic                    p2_v_q;
  logic [IW-1:0]           p2_idx_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  int                      row_v;
  int                      idx_v;

  assign addr_rd = addr_q;
  assign X       = x_q;
  assign x_valid = x_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

  // Lane values for the next wavefront step; forwards the word landing this cycle.
  always_comb begin
    step_d = (state_q == STREAM) ? t_q + TW'(1) : '0;
    x_d    = '0;
    row_v  = 0;
    idx_v  = 0;
    for (int j = 0; j < N; j++) begin
      row_v = int'(step_d) - j;
      if (row_v >= 0 && row_v < M) begin
        idx_v = row_v * N + j;
        if (p2_v_q && p2_idx_q == IW'(idx_v)) begin
          x_d[j*DATA_WIDTH +: DATA_WIDTH] = data_rd;
        end else begin
          x_d[j*DATA_WIDTH +: DATA_WIDTH] = mem_q[IW'(idx_v)];
        end
      end
    end
  end

  // Matrix buffer: capture read data one cycle after its address was presented.
  always_ff @(posedge clk) begin
    if (p2_v_q) begin
      mem_q[p2_idx_q] <= data_rd;
    end
  end

  // Control FSM with registered outputs; DRAIN holds until the last word has landed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      r_q       <= '0;
      t_q       <= '0;
      addr_q    <= '0;
      x_q       <= '0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      p1_v_q    <= 1'b0;
      p1_idx_q  <= '0;
      p2_v_q    <= 1'b0;
      p2_idx_q  <= '0;
    end else begin
      p1_v_q   <= 1'b0;
      p2_v_q   <= p1_v_q;
      p2_idx_q <= p1_idx_q;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= LOAD;
            r_q     <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        LOAD: begin
          addr_q   <= IM2COL_BASE + ADDR_WIDTH'(r_q);
          p1_v_q   <= 1'b1;
          p1_idx_q <= r_q;
          if (r_q == LAST_R) begin
            r_q     <= '0;
            state_q <= DRAIN;
          end else begin
            r_q <= r_q + IW'(1);
          end
        end
        DRAIN: begin
          if (p2_v_q && !p1_v_q) begin
            state_q   <= STREAM;
            t_q       <= '0;
            x_q       <= x_d;
            x_valid_q <= 1'b1;
          end
        end
        STREAM: begin
          if (x_ready) begin
            if (t_q == LAST_T) begin
              state_q   <= DONE;
              t_q       <= '0;
              x_q       <= '0;
              x_valid_q <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              t_q <= t_q + TW'(1);
              x_q <= x_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_im2col_feeder.sv
// tb/tb_im2col_feeder.sv - scoreboard bench for im2col_feeder
module tb_im2col_feeder;

  logic         clk;
  logic         rst;
  logic         start;
  logic [31:0]  addr_rd;
  logic [31:0]  data_rd;
  logic [287:0] X;
  logic         x_valid;
  logic         x_ready;
  logic         busy;
  logic         done;

  logic         start_s;
  logic [31:0]  addr_s;
  logic [31:0]  data_s;
  logic [63:0]  X_s;
  logic         xv_s;
  logic         x_ready_s;
  logic         busy_s;
  logic         done_s;

  logic [31:0]  mem_b [0:179];
  logic [31:0]  mem_s [0:3];
  logic [31:0]  off_b;
  logic [31:0]  off_s;

  logic [287:0] exp_q [$];
  logic [63:0]  exp_s_q [$];
  int           checks;
  int           failures;
  int           vcnt;
  int           vcnt_s;
  int           acc;
  int           last_stall;
  int           spot_pass;
  bit           stall_mode;
  bit           hold_chk;
  logic [287:0] held;

  im2col_feeder dut (
    .clk(clk), .rst(rst), .start(start), .addr_rd(addr_rd), .data_rd(data_rd),
    .X(X), .x_valid(x_valid), .x_ready(x_ready), .busy(busy), .done(done)
  );

  im2col_feeder #(.M(2), .N(2)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .addr_rd(addr_s), .data_rd(data_s),
    .X(X_s), .x_valid(xv_s), .x_ready(x_ready_s), .busy(busy_s), .done(done_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    off_b = addr_rd - 32'h2000;
    off_s = addr_s - 32'h2000;
    data_rd <= (off_b < 180) ? mem_b[off_b[7:0]] : 32'h0;
    data_s  <= (off_s < 4) ? mem_s[off_s[1:0]] : 32'h0;
  end

  task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor for the full-size instance.
  always @(negedge clk) begin
    if (rst) begin
      if (x_valid) vcnt++;
      if (hold_chk) begin
        check("stall_hold", X, held);
        hold_chk = 0;
      end
      if (x_valid && !x_ready) begin
        held = X;
        hold_chk = 1;
      end
      if (x_valid && x_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_step", 288'(acc), 288'hFFFF);
        end else begin
          check("step", X, exp_q.pop_front());
          if (spot_pass == 1 && acc == 0) begin
            check("t0_lane0", 288'(X[31:0]), 288'h0);
            check("t0_others", 288'(X[287:32]), 288'h0);
          end
          if (spot_pass == 1 && acc == 10) begin
            check("t10_lane0", 288'(X[31:0]), 288'h000A0000);
            check("t10_lane8", 288'(X[287:256]), 288'h00020008);
          end
          if (spot_pass == 1 && acc == 27) check("t27", X, {32'h00130008, 256'h0});
          if (spot_pass == 2 && acc == 0) check("restart_t0_lane0", 288'(X[31:0]), 288'h01000000);
        end
        acc++;
      end
    end
  end

  // Monitor for the small instance.
  always @(negedge clk) begin
    if (rst && xv_s) begin
      vcnt_s++;
      if (exp_s_q.size() == 0) check("small_unexpected", 288'(X_s), 288'h0);
      else check("small_step", 288'(X_s), 288'(exp_s_q.pop_front()));
    end
  end

  // Backpressure driver: stall one cycle on selected steps.
  initial begin
    x_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_mode && (acc inside {5, 6, 7, 20}) && last_stall != acc) begin
        x_ready = 1'b0;
        last_stall = acc;
      end else begin
        x_ready = 1'b1;
      end
    end
  end

  task automatic fill_mem(input int hi);
    for (int i = 0; i < 20; i++)
      for (int j = 0; j < 9; j++)
        mem_b[i*9+j] = {16'(i + hi), 16'(j)};
  endtask

  task automatic push_expected(input int hi);
    logic [287:0] e;
    int row;
    for (int t = 0; t < 28; t++) begin
      e = '0;
      for (int j = 0; j < 9; j++) begin
        row = t - j;
        if (row >= 0 && row < 20) e[j*32 +: 32] = {16'(row + hi), 16'(j)};
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic run_pass(input string tag, input int exp_valid, input int hi,
                          input bit inj_load, input bit inj_stream);
    int cnt;
    int aerr;
    vcnt = 0;
    acc = 0;
    last_stall = -1;
    push_expected(hi);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_done_clear"}, 288'(done), 288'h0);
    check({tag, "_busy"}, 288'(busy), 288'h1);
    cnt = 0;
    aerr = 0;
    while (!x_valid && cnt < 400) begin
      @(posedge clk);
      #1;
      cnt++;
      start = inj_load && cnt == 50;
      if (cnt <= 180) begin
        if (addr_rd != 32'h2000 + 32'(cnt - 1)) aerr++;
      end else if (addr_rd != 32'h20B3) aerr++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 288'(cnt), 288'd182);
    check({tag, "_addr_sweep_errors"}, 288'(aerr), 288'h0);
    if (inj_stream) begin
      repeat (6) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 200) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    check({tag, "_steps_left"}, 288'(exp_q.size()), 288'h0);
    check({tag, "_done_early"}, 288'(done), 288'h0);
    @(posedge clk);
    #1;
    check({tag, "_done"}, 288'(done), 288'h1);
    check({tag, "_done_state"}, 288'({busy, x_valid}), 288'h0);
    check({tag, "_done_X"}, X, 288'h0);
    check({tag, "_valid_cycles"}, 288'(vcnt), 288'(exp_valid));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int cnt;
    checks = 0;
    failures = 0;
    vcnt = 0;
    vcnt_s = 0;
    acc = 0;
    last_stall = -1;
    spot_pass = 0;
    stall_mode = 0;
    hold_chk = 0;
    held = '0;
    start = 1'b0;
    start_s = 1'b0;
    x_ready_s = 1'b1;
    rst = 1'b0;
    fill_mem(0);
    mem_s[0] = 32'd1;
    mem_s[1] = 32'd2;
    mem_s[2] = 32'd3;
    mem_s[3] = 32'd4;

    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", 288'(addr_rd), 288'h0);
    check("rst_X", X, 288'h0);
    check("rst_valid", 288'(x_valid), 288'h0);
    check("rst_busy", 288'(busy), 288'h0);
    check("rst_done", 288'(done), 288'h0);
    @(negedge clk);
    rst = 1'b1;

    spot_pass = 1;
    run_pass("basic", 28, 0, 0, 0);
    spot_pass = 0;
    stall_mode = 1;
    run_pass("stall", 32, 0, 0, 0);
    stall_mode = 0;
    run_pass("ignore", 28, 0, 1, 1);
    fill_mem('h100);
    spot_pass = 2;
    run_pass("restart", 28, 'h100, 0, 0);
    spot_pass = 0;

    push_expected('h100);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cnt = 0;
    while (!x_valid && cnt < 400) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("abort_reached_stream", 288'(x_valid), 288'h1);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("abort_X", X, 288'h0);
    check("abort_valid", 288'(x_valid), 288'h0);
    check("abort_busy", 288'(busy), 288'h0);
    check("abort_done", 288'(done), 288'h0);
    check("abort_addr", 288'(addr_rd), 288'h0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_idle", 288'({done, busy, x_valid}), 288'h0);

    exp_s_q.push_back(64'h00000000_00000001);
    exp_s_q.push_back(64'h00000002_00000003);
    exp_s_q.push_back(64'h00000004_00000000);
    vcnt_s = 0;
    @(negedge clk);
    start_s = 1'b1;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    cnt = 0;
    while (!xv_s && cnt < 50) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("small_latency", 288'(cnt), 288'd6);
    cnt = 0;
    while (exp_s_q.size() != 0 && cnt < 50) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    check("small_steps_left", 288'(exp_s_q.size()), 288'h0);
    @(posedge clk);
    #1;
    check("small_done", 288'({done_s, busy_s, xv_s}), 288'h4);
    check("small_valid_cycles", 288'(vcnt_s), 288'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
